mem_datos_ctrl: RTL and testbench
=================================

// Module: mem_datos_ctrl
// PURPOSE
// MEM-stage initiator for ram_datos: turns MIPS load/store requests (lb/lbu/lh/lhu/lw/sb/sh/sw)
// into word accesses on the single-port RAM. Sign- or zero-extends loads. Does read-modify-write
// for sub-word stores, because the RAM has no byte enables. Stalls the pipeline via req_ready.
// Sits between the EX/MEM register and ram_datos; the RAM's own reset pin is tied off externally.
// PARAMETERS
// RAM_DEPTH     2048  words in ram_datos; ADDR_W = clogb2(RAM_DEPTH-1) (11 at default)
// READ_LATENCY  2     RAM read latency: 2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY; other values illegal
// PORTS
// clka        in   1       clock, rising edge
// rsta        in   1       synchronous active-high reset
// req_valid   in   1       request present
// req_ready   out  1       controller idle; request accepted on edge when req_valid&req_ready
// req_we      in   1       1 = store, 0 = load
// req_size    in   2       00 byte, 01 half, 10 word (11 treated as misaligned)
// req_unsign  in   1       loads only: 1 = zero-extend, 0 = sign-extend
// req_addr    in   32      byte address; bits [31:ADDR_W+2] ignored (address wraps)
// req_wdata   in   32      store data, right-justified (sb uses [7:0], sh uses [15:0])
// rsp_valid   out  1       one-cycle completion pulse for every accepted request
// rsp_rdata   out  32      load result, valid with rsp_valid; 0 for stores/errors
// rsp_err     out  1       misaligned access, valid with rsp_valid
// ram_addra   out  ADDR_W  word index = req_addr[ADDR_W+1:2]
// ram_dina    out  32      RAM write data
// ram_wea     out  1       RAM write enable
// ram_ena     out  1       RAM enable
// ram_regcea  out  1       RAM output register enable
// ram_douta   in   32      RAM read data
// BEHAVIOUR
// - All outputs are registered. Reset: req_ready=1; all other outputs 0; state IDLE.
// - Lanes are little-endian: byte n = bits [8n+7:8n], n = addr[1:0]; half uses addr[1] (0 -> [15:0]).
// - States: IDLE, RD_ISSUE, RD_WAIT, MERGE, WR, RESP.
// - req_ready=1 only in IDLE. A request is accepted on edge E0.
// - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size=11):
//   IDLE->RESP; no RAM access; after E1, rsp_valid=1, rsp_err=1, rsp_rdata=0.
// - sw: IDLE->WR. During the cycle after E0, ena=wea=1 and dina=wdata; the RAM writes on E1.
//   Then RESP; rsp_valid is high after E1; back to IDLE.
// - Load: IDLE->RD_ISSUE. During the cycle after E0, ena=1 and wea=0; the RAM samples on E1.
//   RD_WAIT counts READ_LATENCY-1 cycles, with regcea=1 throughout.
//   ram_douta is captured on edge E(1+READ_LATENCY).
//   The selected lane is extended and rsp_rdata/rsp_valid are presented on the next edge.
//   Total: rsp_valid is high in the cycle after edge E(2+READ_LATENCY).
// - sb/sh: read exactly as a load, then MERGE replaces only the addressed lane(s) in the captured word.
//   WR then writes the merged word; RESP follows as for sw. Other bytes of the word are preserved.
// - ena and wea drop to 0 in every state except RD_ISSUE and WR. regcea is 1 only in RD_WAIT.
// - RESP lasts exactly 1 cycle and returns to IDLE; a new request can be accepted on the following edge.
// - req_* inputs are sampled only at acceptance; later changes have no effect.
// - rsta in any state: return to IDLE on that edge and clear all outputs. An in-flight RMW is
//   abandoned and the RAM is not written; an in-flight request gets no rsp_valid.
// - rsta has priority over req_valid on the same edge.
// TESTING
// 1 sw 0xDEADBEEF @0x10; lw @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 4 cycles after accept (LAT=2).
// 2 sb 0x..AA @0x11 on the word above; lw @0x10 -> 0xDEADAAEF; exactly one ram_wea pulse.
// 3 On 0xDEADAAEF: lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000AAEF.
// 4 lw @0x02 and lh @0x01 -> rsp_err=1, rsp_rdata=0, ram_ena never asserted, rsp_valid 1 cycle after accept.
// 5 sh 0x1234 @0x10, rsta pulsed during RD_WAIT -> no ram_wea, no rsp_valid; lw @0x10 still 0xDEADAAEF.
// 6 Rerun tests 1-3 with READ_LATENCY=1 against a LOW_LATENCY RAM -> same data, load response 1 cycle earlier.

Source files
------------

// File: rtl/mem_datos_ctrl.sv
// MEM-stage load/store initiator for the ram_datos word RAM.
// Handles sub-word loads (lane select + extension) and sub-word stores
// (read-modify-write, since the RAM has no byte enables). All outputs registered.
module mem_datos_ctrl #(
  parameter int RAM_DEPTH    = 2048,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(RAM_DEPTH)
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  output logic              ram_wea,
  output logic              ram_ena,
  output logic              ram_regcea,
  input  logic [31:0]       ram_douta
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, MERGE, WR, RESP} state_t;

  state_t state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic        op_we, op_uns, op_err;
  logic [1:0]  op_size, op_lane;
  logic [15:0] op_wdata;
  logic [31:0] rd_word, rd_word_n;

  logic              mis;
  logic [ADDR_W-1:0] addra_n;
  logic [31:0]       dina_n, rdata_n;
  logic              err_n;

  logic [4:0]  sh_b, sh_h;
  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic [31:0] load_val, mask, data, merged;

  // Address bits above the RAM wrap silently.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign mis = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    sh_b     = {op_lane, 3'b000};
    sh_h     = {op_lane[1], 4'b0000};
    byte_w   = 8'(rd_word >> sh_b);
    half_w   = 16'(rd_word >> sh_h);
    load_val = rd_word;
    mask     = 32'hFFFF_FFFF;
    data     = {16'b0, op_wdata};
    case (op_size)
      2'b00: begin
        load_val = op_uns ? {24'b0, byte_w} : {{24{byte_w[7]}}, byte_w};
        mask     = 32'h0000_00FF << sh_b;
        data     = {24'b0, op_wdata[7:0]} << sh_b;
      end
      2'b01: begin
        load_val = op_uns ? {16'b0, half_w} : {{16{half_w[15]}}, half_w};
        mask     = 32'h0000_FFFF << sh_h;
        data     = {16'b0, op_wdata} << sh_h;
      end
      default: ;
    endcase
    merged = (rd_word & ~mask) | (data & mask);
  end

  // Next state plus next values of the registered outputs.
  // Misaligned requests idle one cycle in MERGE so their response lands
  // one cycle after acceptance, like a word store.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rd_word_n = rd_word;
    addra_n   = ram_addra;
    dina_n    = ram_dina;
    rdata_n   = '0;
    err_n     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        addra_n = req_addr[ADDR_W+1:2];
        if (mis)                            state_n = MERGE;
        else if (req_we && req_size == 2'b10) begin
          state_n = WR;
          dina_n  = req_wdata;
        end else                            state_n = RD_ISSUE;
      end
      RD_ISSUE: begin
        state_n = RD_WAIT;
        cnt_n   = 2'(READ_LATENCY - 1);
      end
      RD_WAIT: begin
        if (cnt == 2'd0) begin
          state_n   = MERGE;
          rd_word_n = ram_douta;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      MERGE: begin
        if (op_err) begin
          state_n = RESP;
          err_n   = 1'b1;
        end else if (op_we) begin
          state_n = WR;
          dina_n  = merged;
        end else begin
          state_n = RESP;
          rdata_n = load_val;
        end
      end
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, captured request fields and registered outputs.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_word    <= '0;
      op_we      <= 1'b0;
      op_uns     <= 1'b0;
      op_err     <= 1'b0;
      op_size    <= '0;
      op_lane    <= '0;
      op_wdata   <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      ram_wea    <= 1'b0;
      ram_ena    <= 1'b0;
      ram_regcea <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_word <= rd_word_n;
      if (state == IDLE && req_valid) begin
        op_we    <= req_we;
        op_uns   <= req_unsign;
        op_err   <= mis;
        op_size  <= req_size;
        op_lane  <= req_addr[1:0];
        op_wdata <= req_wdata[15:0];
      end
      req_ready  <= (state_n == IDLE);
      rsp_valid  <= (state_n == RESP);
      rsp_rdata  <= rdata_n;
      rsp_err    <= err_n;
      ram_addra  <= addra_n;
      ram_dina   <= dina_n;
      ram_wea    <= (state_n == WR);
      ram_ena    <= (state_n == RD_ISSUE) || (state_n == WR);
      ram_regcea <= (state_n == RD_WAIT);
    end
  end

endmodule

// File: tb/tb_mem_datos_ctrl.sv
// Scoreboard bench: two controllers (READ_LATENCY 2 and 1), each on its own
// behavioural RAM, driven with identical directed and random requests.
module tb_mem_datos_ctrl;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_we, req_unsign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic          rdy2, vld2, err2, wea2, ena2, rce2;
  logic [31:0]   rd2, din2, dout2;
  logic [AW-1:0] addr2;
  logic          rdy1, vld1, err1, wea1, ena1, rce1;
  logic [31:0]   rd1, din1, dout1;
  logic [AW-1:0] addr1;

  mem_datos_ctrl #(.RAM_DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
    .clka(clk), .rsta(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
    .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld2), .rsp_rdata(rd2), .rsp_err(err2), .ram_addra(addr2), .ram_dina(din2),
    .ram_wea(wea2), .ram_ena(ena2), .ram_regcea(rce2), .ram_douta(dout2));

  mem_datos_ctrl #(.RAM_DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clka(clk), .rsta(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1), .ram_addra(addr1), .ram_dina(din1),
    .ram_wea(wea1), .ram_ena(ena1), .ram_regcea(rce1), .ram_douta(dout1));

  // HIGH_PERFORMANCE RAM: array latch then output register gated by regcea.
  logic [31:0] mem2 [DEPTH] = '{default: '0};
  logic [31:0] latch2 = '0;
  initial dout2 = '0;
  always @(posedge clk) begin
    if (ena2) begin
      if (wea2) mem2[addr2] <= din2;
      latch2 <= mem2[addr2];
    end
    if (rce2) dout2 <= latch2;
  end

  // LOW_LATENCY RAM: data straight from the array one edge after the address.
  logic [31:0] mem1 [DEPTH] = '{default: '0};
  initial dout1 = '0;
  always @(posedge clk) begin
    if (ena1) begin
      if (wea1) mem1[addr1] <= din1;
      dout1 <= mem1[addr1];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc, lat2, lat1, ena_n, wea_n;
  } exp_t;

  exp_t        q2[$], q1[$];
  logic [31:0] mdl [DEPTH];
  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the READ_LATENCY=2 instance.
  initial begin : mon2
    exp_t e;
    int ec, wc;
    ec = 0; wc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin ec = 0; wc = 0; end
      else begin
        if (ena2) ec++;
        if (wea2) wc++;
        if (vld2) begin
          if (q2.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL L2 unexpected rsp_valid at cycle %0d: got rdata 0x%08h, want no response", cyc, rd2);
          end else begin
            e = q2.pop_front();
            chk("L2 rdata", rd2, e.rdata);
            chk("L2 err", 32'(err2), 32'(e.err));
            chk("L2 latency", 32'(cyc - e.acc), 32'(e.lat2));
            chk("L2 wea pulses", 32'(wc), 32'(e.wea_n));
            chk("L2 ena cycles", 32'(ec), 32'(e.ena_n));
          end
          ec = 0; wc = 0;
        end
      end
    end
  end

  // Monitor for the READ_LATENCY=1 instance.
  initial begin : mon1
    exp_t e;
    int ec, wc;
    ec = 0; wc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin ec = 0; wc = 0; end
      else begin
        if (ena1) ec++;
        if (wea1) wc++;
        if (vld1) begin
          if (q1.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL L1 unexpected rsp_valid at cycle %0d: got rdata 0x%08h, want no response", cyc, rd1);
          end else begin
            e = q1.pop_front();
            chk("L1 rdata", rd1, e.rdata);
            chk("L1 err", 32'(err1), 32'(e.err));
            chk("L1 latency", 32'(cyc - e.acc), 32'(e.lat1));
            chk("L1 wea pulses", 32'(wc), 32'(e.wea_n));
            chk("L1 ena cycles", 32'(ec), 32'(e.ena_n));
          end
          ec = 0; wc = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (rdy1 && rdy2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL idle timeout: req_ready L2=%0b L1=%0b, want both 1", rdy2, rdy1);
    end
  endtask

  // Reference: byte-addressed little-endian memory semantics, applied at issue.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int idx, sh;
    logic [31:0] w, v, m;
    idx = int'(addr[12:2]);
    sh  = (size == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
    e.rdata = '0; e.acc = cyc + 1; e.ena_n = 0; e.wea_n = 0;
    e.err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 0);
    if (e.err) begin
      e.lat2 = 1; e.lat1 = 1;
    end else if (we) begin
      e.wea_n = 1;
      if (size == 2'b10) begin
        mdl[idx] = wdata; e.ena_n = 1; e.lat2 = 1; e.lat1 = 1;
      end else begin
        m = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        mdl[idx] = (mdl[idx] & ~m) | ((wdata << sh) & m);
        e.ena_n = 2; e.lat2 = 5; e.lat1 = 4;
      end
    end else begin
      w = mdl[idx];
      v = w >> sh;
      e.ena_n = 1; e.lat2 = 4; e.lat1 = 3;
      if (size == 2'b00)      e.rdata = uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (size == 2'b01) e.rdata = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                    e.rdata = w;
    end
    q2.push_back(e);
    q1.push_back(e);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsign = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus: it must only be sampled at acceptance.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsign = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    wait_idle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " L2 req_ready"}, 32'(rdy2), 32'd1);
    chk({tag, " L1 req_ready"}, 32'(rdy1), 32'd1);
    chk({tag, " L2 outputs"}, {vld2, err2, wea2, ena2, rce2} | rd2 | din2 | 32'(addr2), 32'd0);
    chk({tag, " L1 outputs"}, {vld1, err1, wea1, ena1, rce1} | rd1 | din1 | 32'(addr1), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        wflag;
    logic [31:0] a;
    int          s;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsign = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    // Reset must win over a simultaneous request.
    req_valid = 1'b1; req_size = 2'b10;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    chk_reset_state("reset");

    // Word store/load, then byte merge and the extension cases.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    // Misaligned requests.
    issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555);
    // Address wrap: high bits ignored.
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_E014, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);

    // Abort an sh mid-read: no write, no response, memory untouched.
    wflag = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsign = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1234;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; wflag |= wea2 | wea1;
    @(posedge clk); @(negedge clk);
    wflag |= wea2 | wea1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_reset_state("abort");
    for (int i = 0; i < 6; i++) begin
      wflag |= wea2 | wea1;
      @(negedge clk);
    end
    chk("abort ram_wea seen", 32'(wflag), 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    // Random traffic over a small window of words.
    for (int n = 0; n < 150; n++) begin
      s = int'($urandom_range(0, 9));
      a = $urandom;
      a[12:6] = '0;
      if ($urandom_range(0, 3) != 0) begin
        if (s >= 6) a[1:0] = 2'b00;
        else if (s >= 3) a[0] = 1'b0;
      end
      issue(1'($urandom), (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11,
            1'($urandom), a, $urandom);
    end

    repeat (10) @(negedge clk);
    chk("L2 responses outstanding", 32'(q2.size()), 32'd0);
    chk("L1 responses outstanding", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
